// File: rtl/ip_seno_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ip_seno_pkg
//  Purpose  : Shared constants and FSM state types for the IP_seno register bank
//  Revision : 1.0 - initial release
// ============================================================================
package ip_seno_pkg;

    localparam int NUM_REGS = 4;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_PHASE = 2'd1;
    localparam logic [1:0] REG_AMP   = 2'd2;
    localparam logic [1:0] REG_OFFS  = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/ip_seno_axil_regs_if.sv
`default_nettype none
// ============================================================================
//  Module   : ip_seno_axil_regs_if
//  Purpose  : AXI4-Lite bus bundle with master/slave views
//  Revision : 1.0 - initial release
// ============================================================================
interface ip_seno_axil_regs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface
`default_nettype wire

// File: rtl/axil_wstrb_merge.sv
`default_nettype none
// ============================================================================
//  Module   : axil_wstrb_merge
//  Purpose  : Byte-enable merge of write data into an existing register value
//  Revision : 1.0 - initial release
// ============================================================================
module axil_wstrb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  wire [DATA_WIDTH-1:0]   i_old,
    input  wire [DATA_WIDTH-1:0]   i_wdata,
    input  wire [DATA_WIDTH/8-1:0] i_wstrb,
    output logic [DATA_WIDTH-1:0]  o_merged
);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_byte
            assign o_merged[gi*8 +: 8] = i_wstrb[gi] ? i_wdata[gi*8 +: 8] : i_old[gi*8 +: 8];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ip_seno_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : ip_seno_axil_regs
//  Purpose  : AXI4-Lite responder holding the four sine-core config registers
//  Revision : 1.0 - initial release
// ============================================================================
module ip_seno_axil_regs
    import ip_seno_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  wire               ACLK,
    input  wire               ARESET,
    ip_seno_axil_regs_if.slave s_axi,
    output logic              cfg_enable,
    output logic [31:0]       cfg_phase_inc,
    output logic [15:0]       cfg_amplitude,
    output logic [15:0]       cfg_offset,
    output logic              cfg_wr_pulse,
    output logic [1:0]        cfg_wr_idx
);

    localparam int c_dw    = C_S_AXI_DATA_WIDTH;
    localparam int c_sw    = C_S_AXI_DATA_WIDTH / 8;
    localparam int c_idx_w = $clog2(NUM_REGS);

    logic [c_dw-1:0]    r_regs [NUM_REGS];

    wr_state_t          r_wstate;
    logic               r_awready;
    logic               r_wready;
    logic               r_bvalid;
    logic [c_idx_w-1:0] r_awidx;
    logic [c_dw-1:0]    r_wdata;
    logic [c_sw-1:0]    r_wstrb;
    logic               r_wr_pulse;
    logic [c_idx_w-1:0] r_wr_idx;

    rd_state_t          r_rstate;
    logic               r_arready;
    logic               r_rvalid;
    logic [c_dw-1:0]    r_rdata;

    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_have_aw;
    logic               w_have_w;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_ar_idx;
    logic [c_dw-1:0]    w_wr_data;
    logic [c_sw-1:0]    w_wr_strb;
    logic [c_dw-1:0]    w_merged;
    logic               w_unused;

    assign w_aw_hs   = s_axi.S_AXI_AWVALID & r_awready;
    assign w_w_hs    = s_axi.S_AXI_WVALID  & r_wready;
    assign w_have_aw = (r_wstate == W_HAVE_AW) | w_aw_hs;
    assign w_have_w  = (r_wstate == W_HAVE_W)  | w_w_hs;

    // A channel arriving this cycle takes priority over the previously latched copy
    assign w_wr_idx  = w_aw_hs ? s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : r_awidx;
    assign w_wr_data = w_w_hs  ? s_axi.S_AXI_WDATA : r_wdata;
    assign w_wr_strb = w_w_hs  ? s_axi.S_AXI_WSTRB : r_wstrb;
    assign w_ar_idx  = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    axil_wstrb_merge #(
        .DATA_WIDTH (c_dw)
    ) u_merge (
        .i_old    (r_regs[w_wr_idx]),
        .i_wdata  (w_wr_data),
        .i_wstrb  (w_wr_strb),
        .o_merged (w_merged)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_awidx    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wr_pulse <= 1'b0;
            r_wr_idx   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_pulse <= 1'b0;
            case (r_wstate)
                W_IDLE, W_HAVE_AW, W_HAVE_W: begin
                    if (w_have_aw && w_have_w) begin
                        r_regs[w_wr_idx] <= w_merged;
                        // An all-zero strobe is still acknowledged but is not a config change
                        if (|w_wr_strb) begin
                            r_wr_pulse <= 1'b1;
                            r_wr_idx   <= w_wr_idx;
                        end
                        r_bvalid  <= 1'b1;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_wstate  <= W_RESP;
                    end else if (w_have_aw) begin
                        r_awidx   <= w_wr_idx;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_HAVE_AW;
                    end else if (w_have_w) begin
                        r_wdata   <= w_wr_data;
                        r_wstrb   <= w_wr_strb;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                        r_wstate  <= W_HAVE_W;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Reads sample the register array before this edge's write lands
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_axi.S_AXI_ARVALID && r_arready) begin
                        r_rdata   <= r_regs[w_ar_idx];
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.S_AXI_RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = AXI_RESP_OKAY;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = AXI_RESP_OKAY;

    assign cfg_enable    = r_regs[REG_CTRL][0];
    assign cfg_phase_inc = r_regs[REG_PHASE][31:0];
    assign cfg_amplitude = r_regs[REG_AMP][15:0];
    assign cfg_offset    = r_regs[REG_OFFS][15:0];
    assign cfg_wr_pulse  = r_wr_pulse;
    assign cfg_wr_idx    = r_wr_idx;

    assign w_unused = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire
